// File: rtl/usr_seq_controller.sv
// ----------------------------------------------------------------------------
// usr_seq_controller
//
// Sequencer for a universal_shift_register instance. A host hands over a
// parallel word through a valid/ready handshake. The controller then
// parallel-loads the word into the register and shifts it out one bit per
// cycle in the chosen direction, while shifting the serial input in. When the
// transfer ends, the register is held and the word that was shifted in is
// published on rx_data. This block is the only driver of the register's sel
// pins.
//
// Optional feature (compile-time macro):
//   USR_SEQ_LOOPBACK_EN - when defined, the bit leaving the register is fed
//                         back into SI during SHIFT. The transfer becomes a
//                         rotation, so rx_data equals the accepted tx_data.
//                         In this build ser_in is ignored.
//
// Parameters:
//   WIDTH  register width (>= 2). Must match the shift register instance.
//   CNT_W  bit-counter width. 2**CNT_W must be greater than WIDTH.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   start_valid  in   host transfer request
//   start_ready  out  high only in IDLE
//   tx_data      in   word to send, sampled at accept
//   dir          in   sampled at accept: 0 = left/MSB first, 1 = right/LSB first
//   abort        in   synchronous cancel, honoured in LOAD and SHIFT
//   ser_in       in   external serial input, forwarded to usr_si in SHIFT
//   ser_out      out  bit leaving the register this cycle (SHIFT only)
//   ser_en       out  high on every SHIFT cycle
//   usr_sel      out  register sel: 00 hold, 01 left, 10 right, 11 load
//   usr_pi       out  register PI (the latched tx word)
//   usr_si       out  register SI
//   usr_po       in   register PO
//   done         out  one-cycle pulse in the DONE state
//   rx_data      out  last received word
//   rx_valid     out  rx_data holds a completed transfer
//   dbg_state    out  current FSM state (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//
// Handshake: a request is accepted on a rising clk edge where both
// start_valid and start_ready are high. start_ready depends only on the
// state, never on start_valid. The host may hold start_valid high for as
// long as it likes: nothing is taken until start_ready is also high.
// ----------------------------------------------------------------------------
module usr_seq_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             dir,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_en,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pi,
    output logic             usr_si,
    input  logic [WIDTH-1:0] usr_po,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [1:0]       dbg_state
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Register sel codes
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    // Count value of the final SHIFT cycle
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             dir_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             shift_out_bit;

    assign accept    = start_valid && (state == ST_IDLE);
    assign dbg_state = state;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // abort takes priority, even on the final bit.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (bit_cnt == LAST_BIT) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            dir_q    <= 1'b0;
            bit_cnt  <= '0;
            usr_pi   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        usr_pi   <= tx_data;
                        dir_q    <= dir;
                        rx_valid <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    // The register is held during DONE, so PO is the
                    // finished word.
                    rx_data  <= usr_po;
                    rx_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // Left shifts move the MSB out; right shifts move the LSB out.
    assign shift_out_bit = dir_q ? usr_po[0] : usr_po[WIDTH-1];

    always_comb begin
        start_ready = 1'b0;
        usr_sel     = SEL_HOLD;
        ser_en      = 1'b0;
        ser_out     = 1'b0;
        usr_si      = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
            end
            ST_LOAD: begin
                // An abort in LOAD must leave the register untouched, so the
                // load command is withdrawn in that cycle.
                usr_sel = abort ? SEL_HOLD : SEL_LOAD;
            end
            ST_SHIFT: begin
                usr_sel = dir_q ? SEL_RIGHT : SEL_LEFT;
                ser_en  = 1'b1;
                ser_out = shift_out_bit;
`ifdef USR_SEQ_LOOPBACK_EN
                usr_si  = shift_out_bit;
`else
                usr_si  = ser_in;
`endif
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef USR_SEQ_LOOPBACK_EN
    // In loopback the external serial input has no consumer.
    logic unused_ser_in;
    assign unused_ser_in = ser_in;
`endif

endmodule

// File: tb/tb_usr_seq_controller.sv
// ----------------------------------------------------------------------------
// tb_usr_seq_controller
//
// Bench for usr_seq_controller with WIDTH=4. A behavioural universal shift
// register is connected to the sel/PI/SI/PO pins. Driver tasks issue
// transfers and push the expected SHIFT-cycle observations ({usr_sel,
// ser_out, usr_si}) and the expected received words onto queues. A monitor
// on the falling edge pops those queues whenever the DUT shows ser_en or
// completes a transfer.
// ----------------------------------------------------------------------------
module tb_usr_seq_controller;

    localparam int WIDTH = 4;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] tx_data = '0;
    logic             dir = 1'b0;
    logic             abort = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_out;
    logic             ser_en;
    logic [1:0]       usr_sel;
    logic [WIDTH-1:0] usr_pi;
    logic             usr_si;
    logic [WIDTH-1:0] usr_po;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [1:0]       dbg_state;

    usr_seq_controller #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .tx_data    (tx_data),
        .dir        (dir),
        .abort      (abort),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_en     (ser_en),
        .usr_sel    (usr_sel),
        .usr_pi     (usr_pi),
        .usr_si     (usr_si),
        .usr_po     (usr_po),
        .done       (done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .dbg_state  (dbg_state)
    );

    // Behavioural universal shift register (not reset by the controller).
    logic [WIDTH-1:0] sr_q = '0;
    assign usr_po = sr_q;
    always @(posedge clk) begin
        case (usr_sel)
            2'b01:   sr_q <= {sr_q[WIDTH-2:0], usr_si};
            2'b10:   sr_q <= {usr_si, sr_q[WIDTH-1:1]};
            2'b11:   sr_q <= usr_pi;
            default: sr_q <= sr_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    logic [3:0]       exp_q[$];   // {usr_sel, ser_out, usr_si} per SHIFT cycle
    logic [WIDTH-1:0] rx_q[$];    // received word per completed transfer

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic si_exp(input logic sin, input logic sout);
`ifdef USR_SEQ_LOOPBACK_EN
        return sout;
`else
        return sin;
`endif
    endfunction

    // Monitor: compares on every SHIFT cycle and one negedge after DONE.
    logic             rx_pending = 1'b0;
    logic [3:0]       mon_e;
    logic [WIDTH-1:0] mon_rx;
    always @(negedge clk) begin
        if (rst) begin
            if (rx_pending) begin
                rx_pending = 1'b0;
                if (rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got done with no transfer expected, rx_data=%0h", rx_data);
                end else begin
                    mon_rx = rx_q.pop_front();
                    check("rx_data", rx_data, mon_rx);
                    check("rx_valid", rx_valid, 1);
                end
            end
            if (ser_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL shift_unexpected: got ser_en=1 with sel=%0b, expected no shift", usr_sel);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("shift_cycle", {usr_sel, ser_out, usr_si}, mon_e);
                end
            end
            if (done) rx_pending = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    // Present a request and return in the LOAD cycle (posedge + 1).
    task automatic issue(input logic [3:0] tx, input logic d);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_issue", start_ready, 1);
        start_valid = 1'b1;
        tx_data     = tx;
        dir         = d;
        @(posedge clk); #1;
        start_valid = 1'b0;
        // Late changes must not disturb the running transfer.
        tx_data     = ~tx;
        dir         = ~d;
        check("accepted_to_load", dbg_state, 2'd1);
        check("pi_latched", usr_pi, tx);
    endtask

    // Full transfer. sin and out_seq read in time order, left (bit 3) first.
    task automatic run_xfer(input logic [3:0] tx, input logic d, input logic [3:0] sin,
                            input logic [3:0] out_seq, input logic [3:0] exp_rx);
        logic [1:0] sel_e;
        sel_e = d ? 2'b10 : 2'b01;
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back({sel_e, out_seq[i], si_exp(sin[i], out_seq[i])});
        end
        rx_q.push_back(exp_rx);
        issue(tx, d);
        check("load_sel", usr_sel, 2'b11);
        check("busy_in_load", start_ready, 0);
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1;
            ser_in = sin[i];
        end
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("done_sel", usr_sel, 2'b00);
        ser_in = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("ready_after_done", start_ready, 1);
    endtask

    // ------------------------------------------------------------------------
    // Expected received words per build
    // ------------------------------------------------------------------------
`ifdef USR_SEQ_LOOPBACK_EN
    localparam logic [3:0] RX_LEFT  = 4'b1010;
    localparam logic [3:0] RX_RIGHT = 4'b1010;
    localparam logic [3:0] RX_LB    = 4'b1011;
    localparam logic [3:0] RX_BUSY1 = 4'b1100;
    localparam logic [3:0] RX_BUSY2 = 4'b0011;
`else
    localparam logic [3:0] RX_LEFT  = 4'b1111;
    localparam logic [3:0] RX_RIGHT = 4'b0110;
    localparam logic [3:0] RX_LB    = 4'b0000;
    localparam logic [3:0] RX_BUSY1 = 4'b1111;
    localparam logic [3:0] RX_BUSY2 = 4'b1111;
`endif

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    logic rdy;
    int   first_acc;
    int   second_acc;
    int   busy_cycles;

    initial begin
        // Reset values, before any clock edge
        #1;
        check("rst_sel", usr_sel, 2'b00);
        check("rst_pi", usr_pi, 0);
        check("rst_si", usr_si, 0);
        check("rst_ser_out", ser_out, 0);
        check("rst_ser_en", ser_en, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_ready", start_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Shift left, ser_in = 1 constant
        run_xfer(4'b1010, 1'b0, 4'b1111, 4'b1010, RX_LEFT);

        // Shift right, ser_in = 0,1,1,0
        run_xfer(4'b1010, 1'b1, 4'b0110, 4'b0101, RX_RIGHT);

        // Reset mid-SHIFT after a completed transfer
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b0, 1'b1)});
        ser_in = 1'b0;
        issue(4'b1001, 1'b0);
        @(posedge clk); #1;   // SHIFT 1
        @(posedge clk); #1;   // SHIFT 2
        rst = 1'b0;
        #1;
        check("midrst_sel", usr_sel, 2'b00);
        check("midrst_ser_en", ser_en, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", start_ready, 1);
        check("midrst_state", dbg_state, 2'd0);
        check("midrst_rx_data", rx_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rx_valid", rx_valid, 0);
        check("post_rst_rx_data", rx_data, 0);
        check("post_rst_ready", start_ready, 1);

        // Complete a transfer so rx_valid is set before the abort
        run_xfer(4'b1010, 1'b0, 4'b1111, 4'b1010, RX_LEFT);

        // Abort on the 2nd SHIFT cycle
        exp_q.push_back({2'b01, 1'b0, si_exp(1'b0, 1'b0)});
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b0, 1'b1)});
        issue(4'b0110, 1'b0);
        @(posedge clk); #1;   // SHIFT 1
        @(posedge clk); #1;   // SHIFT 2
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", dbg_state, 2'd0);
        check("abort_sel", usr_sel, 2'b00);
        check("abort_done", done, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_ready", start_ready, 1);

        // New request straight after the abort (the loopback vector)
        run_xfer(4'b1011, 1'b0, 4'b0000, 4'b1011, RX_LB);

        // Busy requests: start_valid held high across two transfers
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back({2'b01, 4'b1100 >> i & 4'b0001 ? 1'b1 : 1'b0, 1'b0});
        end
        exp_q.delete();
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b1, 1'b1)});
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b1, 1'b1)});
        exp_q.push_back({2'b01, 1'b0, si_exp(1'b1, 1'b0)});
        exp_q.push_back({2'b01, 1'b0, si_exp(1'b1, 1'b0)});
        exp_q.push_back({2'b01, 1'b0, si_exp(1'b1, 1'b0)});
        exp_q.push_back({2'b01, 1'b0, si_exp(1'b1, 1'b0)});
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b1, 1'b1)});
        exp_q.push_back({2'b01, 1'b1, si_exp(1'b1, 1'b1)});
        rx_q.push_back(RX_BUSY1);
        rx_q.push_back(RX_BUSY2);
        ser_in      = 1'b1;
        dir         = 1'b0;
        tx_data     = 4'b1100;
        start_valid = 1'b1;
        first_acc   = -1;
        second_acc  = -1;
        busy_cycles = 0;
        for (int c = 0; c < 40 && second_acc < 0; c++) begin
            rdy = start_ready;
            @(posedge clk); #1;
            if (rdy) begin
                if (first_acc < 0) begin
                    first_acc = c;
                    tx_data   = 4'b0011;
                end else begin
                    second_acc  = c;
                    start_valid = 1'b0;
                end
            end else if (first_acc >= 0) begin
                busy_cycles++;
            end
        end
        start_valid = 1'b0;
        check("busy_accept_gap", second_acc - first_acc, WIDTH + 3);
        check("busy_not_ready_cycles", busy_cycles, WIDTH + 2);
        repeat (WIDTH + 3) begin
            @(posedge clk); #1;
        end
        ser_in = 1'b0;

        // Drain
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("shift_queue_drained", exp_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_seq_controller.md
# usr_seq_controller

Sequencer that drives a `universal_shift_register` instance through serial transfers. It accepts a parallel word over a valid/ready handshake, parallel-loads it, and shifts it out one bit per cycle in the chosen direction while shifting serial input in. It then holds the register and publishes the received word. It sits between a host-side request interface and the register's `sel`/`PI`/`SI`/`PO` pins and is the only block allowed to drive `sel`.

## Interface
Parameters:
- `WIDTH`, default 4: register width; must match the shift register instance; must be ≥ 2.
- `CNT_W`, default 3: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start_valid`  in  1  host requests a transfer.
- `start_ready`  out  1  high only in IDLE; a transfer is accepted on a rising edge where `start_valid` && `start_ready`.
- `tx_data`  in  WIDTH  word to send; sampled at accept.
- `dir`  in  1  sampled at accept; 0 = shift left (MSB first, `sel`=01), 1 = shift right (LSB first, `sel`=10).
- `abort`  in  1  synchronous cancel; effective in LOAD and SHIFT.
- `ser_in`  in  1  external serial input, forwarded to `usr_si` during SHIFT.
- `ser_out`  out  1  bit leaving the register this cycle.
- `ser_en`  out  1  high on every SHIFT cycle.
- `usr_sel`  out  2  to the register's `sel`: 00 hold, 01 left, 10 right, 11 load.
- `usr_pi`  out  WIDTH  to the register's `PI`.
- `usr_si`  out  1  to the register's `SI`.
- `usr_po`  in  WIDTH  from the register's `PO`.
- `done`  out  1  one-cycle pulse at transfer completion.
- `rx_data`  out  WIDTH  last received word.
- `rx_valid`  out  1  `rx_data` holds a completed transfer.

## Operation
The FSM has four states: IDLE, LOAD, SHIFT, DONE. All outputs except `rx_data` and `rx_valid` are decoded from the state and registers.
- **IDLE:** `usr_sel`=00, `start_ready`=1. On accept, latch `tx_data` into `usr_pi`, latch `dir`, clear `rx_valid`, and go to LOAD.
- **LOAD:** one cycle with `usr_sel`=11, so the register loads `usr_pi` at the end of the cycle. Clear `bit_cnt`, then go to SHIFT. If `abort` is high, go to IDLE instead with no load.
- **SHIFT:** exactly WIDTH cycles.
  - `usr_sel`=01 when `dir`=0, 10 when `dir`=1. `ser_en`=1.
  - `ser_out` = `usr_po[WIDTH-1]` when `dir`=0, `usr_po[0]` when `dir`=1.
  - `usr_si` = `ser_in`.
  - `bit_cnt` increments each cycle. When `bit_cnt`==WIDTH-1, go to DONE.
- **DONE:** one cycle with `usr_sel`=00 and `done`=1. At the end of the cycle, `rx_data`<=`usr_po` and `rx_valid`<=1. Then go to IDLE.
- **Abort:** `abort` in SHIFT goes to IDLE on the next edge. No `done`, no `rx_data` update, and `rx_valid` stays 0. The register keeps its partial content under hold.
- **Ignored inputs:** `start_valid` outside IDLE and `abort` in IDLE or DONE are ignored. `tx_data` and `dir` changes after accept have no effect.
- **Undriven cycles:** outside SHIFT, `usr_si`=0, `ser_out`=0, `ser_en`=0.

## Timing
- **Reset values:**
  - state IDLE, `usr_sel`=00, `usr_pi`=0, `usr_si`=0.
  - `ser_out`=0, `ser_en`=0, `done`=0, `rx_data`=0, `rx_valid`=0.
  - `start_ready`=1.
- **Reset mid-transfer:** asserting `rst` in any state forces these values immediately, without waiting for a clock edge. The transfer is lost.
- **Latency:** accept on edge 0 → LOAD in cycle 1 → SHIFT in cycles 2..WIDTH+1 → DONE in cycle WIDTH+2. `rx_data`/`rx_valid` update on the edge ending cycle WIDTH+2.
- **Throughput:** back-to-back accepts occur every WIDTH+3 cycles, because `start_ready` returns in the cycle after DONE.
- **Received word order:** the first `ser_in` bit ends at the MSB for `dir`=0 and at the LSB for `dir`=1.

## Configuration
- `USR_SEQ_LOOPBACK_EN`:
  - Defined: during SHIFT, `usr_si` = `ser_out` and `ser_in` is unused. This makes the transfer a rotation, so the completed `rx_data` equals the accepted `tx_data`.
  - Undefined: `usr_si` = `ser_in` as described in Operation.

## Test plan
All scenarios use WIDTH=4.
1. **Reset:** assert `rst`=0 mid-SHIFT → immediately `usr_sel`=00, `ser_en`=0, `done`=0, `start_ready`=1. After release, `rx_valid`=0 and `rx_data`=0000.
2. **Shift left:** accept `tx_data`=1010, `dir`=0, `ser_in`=1 constant.
   - LOAD has `usr_sel`=11; SHIFT has `usr_sel`=01 for 4 cycles.
   - `ser_out` = 1,0,1,0.
   - `done` in cycle 6 after accept; `rx_data`=1111, `rx_valid`=1.
3. **Shift right:** accept `tx_data`=1010, `dir`=1, `ser_in` = 0,1,1,0 → `usr_sel`=10, `ser_out` = 0,1,0,1, `rx_data`=0110.
4. **Abort:** `abort`=1 on the 2nd SHIFT cycle → IDLE next cycle, `usr_sel`=00, no `done` pulse, `rx_valid`=0. A new request is accepted the cycle after.
5. **Busy requests:** hold `start_valid`=1 throughout a transfer → `start_ready`=0 from LOAD through DONE. The second accept happens exactly WIDTH+3 cycles after the first, with its new `tx_data`.
6. **Loopback build:** with `USR_SEQ_LOOPBACK_EN` defined, `tx_data`=1011, `dir`=0, `ser_in`=0 → `ser_out` = 1,0,1,1 and `rx_data`=1011.
